fpio_fifo_out_server: RTL

//  Server (FIFO-owning) end of the fpio fifo_out protocol: buffers words from an

---
 rtl/fpio_fifo_pkg.sv | 16 +
 rtl/fpio_fifo_out_server_if.sv | 24 ++
 rtl/fpio_fifo_out_server_mem.sv | 39 +++
 rtl/fpio_fifo_out_server.sv | 82 ++++++++
 4 files changed

// File: rtl/fpio_fifo_pkg.sv
// Shared sizing helpers and types for the fpio fifo_in / fifo_out servers.
package fpio_fifo_pkg;
  localparam int FPIO_FIFO_BITS_DEF  = 4;
  localparam int FPIO_DATA_WIDTH_DEF = 8;

  typedef logic [FPIO_FIFO_BITS_DEF-1:0] fpio_ptr_t;
  typedef logic [FPIO_FIFO_BITS_DEF:0]   fpio_count_t;

  function automatic int fpio_depth(input int fifo_bits);
    return 1 << fifo_bits;
  endfunction

  function automatic int fpio_count_w(input int fifo_bits);
    return fifo_bits + 1;
  endfunction
endpackage

// File: rtl/fpio_fifo_out_server_if.sv
// Producer push port plus fifo_out client port of the fifo_out server.
interface fpio_fifo_out_server_if #(
  parameter int FIFO_BITS  = 4,
  parameter int DATA_WIDTH = 8
);
  logic                  wr_valid;
  logic                  wr_ready;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [FIFO_BITS:0]    avail;
  logic [DATA_WIDTH-1:0] data;
  logic                  data_en;
  logic                  data_ack;
  logic                  underflow;

  modport master (
    output wr_valid, wr_data, data_en,
    input  wr_ready, avail, data, data_ack, underflow
  );

  modport slave (
    input  wr_valid, wr_data, data_en,
    output wr_ready, avail, data, data_ack, underflow
  );
endinterface

// File: rtl/fpio_fifo_out_server_mem.sv
// 1W1R register array: write on push, registered read of the head word on pop.
module fpio_fifo_out_server_mem
  import fpio_fifo_pkg::*;
#(
  parameter int FIFO_BITS  = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  wr_en,
  input  logic [FIFO_BITS-1:0]  wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [FIFO_BITS-1:0]  rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);
  localparam int DEPTH = fpio_depth(FIFO_BITS);

  logic [DATA_WIDTH-1:0] mem_r [0:DEPTH-1];
  logic [DATA_WIDTH-1:0] rd_data_r;

  // storage array, no reset: contents are discarded logically via the pointers
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_r[wr_addr] <= wr_data;
    end
  end

  // read register, held between pops
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_data_r <= {DATA_WIDTH{1'b0}};
    end else if (rd_en) begin
      rd_data_r <= mem_r[rd_addr];
    end
  end

  assign rd_data = rd_data_r;
endmodule

// File: rtl/fpio_fifo_out_server.sv
// Server end of the fpio fifo_out protocol: buffers producer words and serves
// them to a client with a one-cycle data_en -> data_ack latency.
module fpio_fifo_out_server
  import fpio_fifo_pkg::*;
#(
  parameter int FIFO_BITS  = 4,
  parameter int DATA_WIDTH = 8
) (
  input logic                   clk,
  input logic                   rstn,
  fpio_fifo_out_server_if.slave bus
);
  localparam int CW = fpio_count_w(FIFO_BITS);
  localparam logic [CW-1:0]        DEPTH_C   = CW'(fpio_depth(FIFO_BITS));
  localparam logic [CW-1:0]        CNT_ONE_C = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0]        CNT_ZERO_C = {CW{1'b0}};
  localparam logic [FIFO_BITS-1:0] PTR_ONE_C = {{(FIFO_BITS-1){1'b0}}, 1'b1};

  logic [FIFO_BITS-1:0] wp_r, rp_r;
  logic [CW-1:0]        count_r, count_next_s;
  logic                 wr_ready_r, ack_r, underflow_r;
  logic                 push_s, pop_s, empty_s;

  // request qualification; data_en is judged on the pre-push count
  always_comb begin
    empty_s = (count_r == CNT_ZERO_C);
    push_s  = bus.wr_valid & wr_ready_r;
    pop_s   = bus.data_en & ~empty_s;
  end

  // occupancy update, unchanged on simultaneous push and pop
  always_comb begin
    count_next_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_next_s = count_r + CNT_ONE_C;
      2'b01:   count_next_s = count_r - CNT_ONE_C;
      default: count_next_s = count_r;
    endcase
  end

  // pointers, count, handshake outputs and sticky underflow
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wp_r        <= {FIFO_BITS{1'b0}};
      rp_r        <= {FIFO_BITS{1'b0}};
      count_r     <= CNT_ZERO_C;
      wr_ready_r  <= 1'b0;
      ack_r       <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      if (push_s) begin
        wp_r <= wp_r + PTR_ONE_C;
      end
      if (pop_s) begin
        rp_r <= rp_r + PTR_ONE_C;
      end
      count_r     <= count_next_s;
      wr_ready_r  <= (count_next_s != DEPTH_C);
      ack_r       <= pop_s;
      underflow_r <= underflow_r | (bus.data_en & empty_s);
    end
  end

  fpio_fifo_out_server_mem #(
    .FIFO_BITS  (FIFO_BITS),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_mem (
    .clk     (clk),
    .rstn    (rstn),
    .wr_en   (push_s),
    .wr_addr (wp_r),
    .wr_data (bus.wr_data),
    .rd_en   (pop_s),
    .rd_addr (rp_r),
    .rd_data (bus.data)
  );

  assign bus.wr_ready  = wr_ready_r;
  assign bus.avail     = count_r;
  assign bus.data_ack  = ack_r;
  assign bus.underflow = underflow_r;
endmodule
